// File: rtl/serial_cmp_ctrl.sv
// Sequencer for the bit-serial magnitude comparator: shifts two parallel operands
// into it LSB-first and registers the three-way result. SERIALCMP_SIGNED_EN selects a two's-complement compare.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for start; comparator held out of clear
// CLEAR  | comparator cleared for one cycle
// SHIFT  | WIDTH cycles, one operand bit pair per cycle, LSB first
// SAMPLE | comparator holds its final decision; captured on exit
// DONE   | one-cycle done pulse
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             err,
    output logic             cmp_a,
    output logic             cmp_b,
    output logic             cmp_reset,
    input  logic             cmp_alessb,
    input  logic             cmp_aequalb,
    input  logic             cmp_agreatb
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] srb;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             shifting;
    logic             onehot;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign shifting = (state == S_SHIFT);
    assign onehot   = ( cmp_alessb & ~cmp_aequalb & ~cmp_agreatb) |
                      (~cmp_alessb &  cmp_aequalb & ~cmp_agreatb) |
                      (~cmp_alessb & ~cmp_aequalb &  cmp_agreatb);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_SHIFT;
            S_SHIFT:  if (last_bit) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // cmp_reset is a flop so it can be low during reset yet high in IDLE afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sra       <= '0;
            srb       <= '0;
            cnt       <= '0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            err       <= 1'b0;
            cmp_reset <= 1'b0;
        end else begin
            cmp_reset <= (state_nxt != S_CLEAR);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sra <= op_a;
                        srb <= op_b;
                        cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    sra <= {1'b0, sra[WIDTH-1:1]};
                    srb <= {1'b0, srb[WIDTH-1:1]};
                    if (!last_bit) cnt <= cnt + CW'(1);
                end
                S_SAMPLE: begin
                    lt  <= cmp_alessb;
                    eq  <= cmp_aequalb;
                    gt  <= cmp_agreatb;
                    err <= ~onehot;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

`ifdef SERIALCMP_SIGNED_EN
    logic swap;
    // Swapping the sign bits lets the last-bit-dominant comparator order signed values.
    assign swap  = shifting & last_bit;
    assign cmp_a = shifting & (swap ? srb[0] : sra[0]);
    assign cmp_b = shifting & (swap ? sra[0] : srb[0]);
`else
    assign cmp_a = shifting & sra[0];
    assign cmp_b = shifting & srb[0];
`endif

endmodule
